// File: rtl/conv_line_sched_if.sv
// Handshake bundle between the line-buffer scheduler, the pixel loader and the conv layer.
// The stall_cnt signal exists only when CONV_LINE_SCHED_STALL_EN is defined.
interface conv_line_sched_if;
  logic        frame_start;
  logic        wr_row_done;
  logic        conv_done;
  logic        wr_allow;
  logic [1:0]  wr_bank;
  logic        conv_start;
  logic [1:0]  rd_base;
  logic [10:0] out_row;
  logic        busy;
  logic        frame_done;
`ifdef CONV_LINE_SCHED_STALL_EN
  logic [15:0] stall_cnt;

  modport master (
    output frame_start, wr_row_done, conv_done,
    input  wr_allow, wr_bank, conv_start, rd_base, out_row, busy, frame_done, stall_cnt
  );
  modport slave (
    input  frame_start, wr_row_done, conv_done,
    output wr_allow, wr_bank, conv_start, rd_base, out_row, busy, frame_done, stall_cnt
  );
`else
  modport master (
    output frame_start, wr_row_done, conv_done,
    input  wr_allow, wr_bank, conv_start, rd_base, out_row, busy, frame_done
  );
  modport slave (
    input  frame_start, wr_row_done, conv_done,
    output wr_allow, wr_bank, conv_start, rd_base, out_row, busy, frame_done
  );
`endif
endinterface

// File: rtl/conv_line_sched.sv
// Four-bank row ring scheduler feeding a 3x3 convolution: grants loader banks, pulses conv start.
// Optional stall counter enabled by defining CONV_LINE_SCHED_STALL_EN.
module conv_line_sched #(
  parameter int ROWS  = 1080,
  parameter int NBANK = 4
) (
  input  logic             clk,
  input  logic             reset,
  conv_line_sched_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_START, S_CONV, S_RETIRE, S_DONE} state_t;

  localparam logic [10:0] ROWS_L   = 11'(ROWS);
  localparam logic [10:0] LAST_OUT = 11'(ROWS - 3);
  localparam logic [1:0]  BANK_MAX = 2'(NBANK - 1);

  state_t      state_q, state_d;
  logic [2:0]  occ_q, occ_d;
  logic [10:0] in_row_q, in_row_d;
  logic [10:0] out_row_q, out_row_d;
  logic [1:0]  wr_bank_q, wr_bank_d;
  logic [1:0]  rd_base_q, rd_base_d;
  logic        wr_allow_c, wr_acc_c, retire_c;

  function automatic logic [1:0] bank_inc(input logic [1:0] b);
    return (b == BANK_MAX) ? 2'd0 : b + 2'd1;
  endfunction

  always_comb begin
    state_d   = state_q;
    occ_d     = occ_q;
    in_row_d  = in_row_q;
    out_row_d = out_row_q;
    wr_bank_d = wr_bank_q;
    rd_base_d = rd_base_q;

    wr_allow_c = (state_q != S_IDLE) && (state_q != S_DONE) &&
                 (occ_q < 3'd4) && (in_row_q < ROWS_L);
    wr_acc_c   = bus.wr_row_done && wr_allow_c;
    retire_c   = (state_q == S_RETIRE);

    if (wr_acc_c) begin
      wr_bank_d = bank_inc(wr_bank_q);
      in_row_d  = in_row_q + 11'd1;
    end
    if (retire_c) rd_base_d = bank_inc(rd_base_q);

    // A write landing on the retire cycle cancels the decrement.
    case ({wr_acc_c, retire_c})
      2'b10:   occ_d = occ_q + 3'd1;
      2'b01:   occ_d = occ_q - 3'd1;
      default: occ_d = occ_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (bus.frame_start) begin
          in_row_d  = '0;
          out_row_d = '0;
          occ_d     = '0;
          rd_base_d = wr_bank_q;
          state_d   = S_FILL;
        end
      end
      S_FILL:  if (occ_q >= 3'd3) state_d = S_START;
      S_START: state_d = S_CONV;
      S_CONV:  if (bus.conv_done) state_d = S_RETIRE;
      S_RETIRE: begin
        if (out_row_q == LAST_OUT) begin
          state_d = S_DONE;
        end else begin
          out_row_d = out_row_q + 11'd1;
          state_d   = S_FILL;
        end
      end
      S_DONE: begin
        occ_d     = '0;
        rd_base_d = wr_bank_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      occ_q     <= '0;
      in_row_q  <= '0;
      out_row_q <= '0;
      wr_bank_q <= '0;
      rd_base_q <= '0;
    end else begin
      state_q   <= state_d;
      occ_q     <= occ_d;
      in_row_q  <= in_row_d;
      out_row_q <= out_row_d;
      wr_bank_q <= wr_bank_d;
      rd_base_q <= rd_base_d;
    end
  end

  assign bus.wr_allow   = wr_allow_c;
  assign bus.wr_bank    = wr_bank_q;
  assign bus.conv_start = (state_q == S_START);
  assign bus.rd_base    = rd_base_q;
  assign bus.out_row    = out_row_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_done = (state_q == S_DONE);

`ifdef CONV_LINE_SCHED_STALL_EN
  logic [15:0] stall_q, stall_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Only starvation after the first output row counts; the initial fill is expected.
  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && bus.frame_start)
      stall_d = '0;
    else if (state_q == S_FILL && occ_q < 3'd3 && out_row_q != 11'd0)
      stall_d = sat_inc16(stall_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign bus.stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_conv_line_sched.sv
// Bench for conv_line_sched: directed vector table, async-reset check, randomized traffic
// against a resident-row reference model, and the stall counter when CONV_LINE_SCHED_STALL_EN is set.
module tb_conv_line_sched;
  localparam int ROWS = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_line_sched_if bus_if ();
  conv_line_sched #(.ROWS(ROWS), .NBANK(4)) dut (.clk(clk), .reset(reset), .bus(bus_if));

  int n_chk  = 0;
  int n_fail = 0;
  int occ_viol = 0;
  int cyc = 0;

  // Reference model: rows resident in the ring, rows written/retired this frame.
  bit          m_busy, m_conv, m_pend, m_end;
  int          m_res, m_written, m_retired, m_age;
  logic [1:0]  m_wrb, m_rdb;
  logic [10:0] m_outrow;
  logic [15:0] m_stall;

  typedef struct {
    bit fs; bit wd; bit cd;
    bit wa; int wrb; bit cs; int rdb; int outr; bit busy; bit fd;
  } vec_t;
  vec_t tbl[$];
  vec_t dummy_v;

  function automatic vec_t mk(bit fs, bit wd, bit cd, bit wa, int wrb, bit cs,
                              int rdb, int outr, bit busy, bit fd);
    vec_t v;
    v.fs = fs; v.wd = wd; v.cd = cd; v.wa = wa; v.wrb = wrb; v.cs = cs;
    v.rdb = rdb; v.outr = outr; v.busy = busy; v.fd = fd;
    return v;
  endfunction

  function automatic logic [18:0] pack_out(bit wa, logic [1:0] wrb, bit cs, logic [1:0] rdb,
                                           logic [10:0] outr, bit busy, bit fd);
    return {wa, wrb, cs, rdb, outr, busy, fd};
  endfunction

  function automatic bit m_wr_allow();
    return m_busy && !m_end && (m_res < 4) && (m_written < ROWS);
  endfunction

  function automatic bit m_elig();
    return m_busy && !m_end && !m_conv && !m_pend && (m_res >= 3);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_conv = 0; m_pend = 0; m_end = 0;
    m_res = 0; m_written = 0; m_retired = 0; m_age = 0;
    m_wrb = 0; m_rdb = 0; m_outrow = 0; m_stall = 0;
  endtask

  task automatic model_step(input bit fs, input bit wd, input bit cd);
    bit acc, el, st, stall_c;
    acc = wd && m_wr_allow();
    el  = m_elig();
    st  = el && (m_age >= 1);
    stall_c = m_busy && !m_end && !m_conv && !m_pend && (m_res < 3) && (m_retired > 0);
    if (!m_busy) begin
      m_age = 0;
      if (fs) begin
        m_busy = 1; m_res = 0; m_written = 0; m_retired = 0;
        m_outrow = 0; m_rdb = m_wrb; m_stall = 0;
      end
    end else if (m_end) begin
      m_busy = 0; m_end = 0; m_res = 0; m_rdb = m_wrb; m_age = 0;
    end else begin
      if (stall_c && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (acc) begin m_res++; m_written++; m_wrb = m_wrb + 2'd1; end
      if (m_pend) begin
        m_pend = 0; m_res--; m_rdb = m_rdb + 2'd1; m_retired++;
        if (m_retired == ROWS - 2) m_end = 1;
        else m_outrow = m_outrow + 11'd1;
      end else if (m_conv) begin
        if (cd) begin m_conv = 0; m_pend = 1; end
      end else if (st) begin
        m_conv = 1;
      end
      m_age = (el && !st) ? m_age + 1 : 0;
    end
  endtask

  task automatic step_core(input bit fs, input bit wd, input bit cd,
                           input bit use_v, input vec_t v, input int idx);
    logic [18:0] act, exp_m, exp_v;
    @(negedge clk);
    cyc++;
    act   = pack_out(bus_if.wr_allow, bus_if.wr_bank, bus_if.conv_start, bus_if.rd_base,
                     bus_if.out_row, bus_if.busy, bus_if.frame_done);
    exp_m = pack_out(m_wr_allow(), m_wrb, m_elig() && (m_age >= 1), m_rdb, m_outrow,
                     m_busy, m_busy && m_end);
    n_chk++;
    if (act !== exp_m) begin
      n_fail++;
      $display("FAIL model cyc=%0d outputs act=%h exp=%h", cyc, act, exp_m);
    end
`ifdef CONV_LINE_SCHED_STALL_EN
    n_chk++;
    if (bus_if.stall_cnt !== m_stall) begin
      n_fail++;
      $display("FAIL stall_model cyc=%0d act=%0d exp=%0d", cyc, bus_if.stall_cnt, m_stall);
    end
`endif
    if (use_v) begin
      exp_v = pack_out(v.wa, 2'(v.wrb), v.cs, 2'(v.rdb), 11'(v.outr), v.busy, v.fd);
      n_chk++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL vec[%0d] outputs act=%h exp=%h", idx, act, exp_v);
      end
    end
    if (dut.occ_q > 3'd4) occ_viol++;
    bus_if.frame_start = fs;
    bus_if.wr_row_done = wd;
    bus_if.conv_done   = cd;
    @(posedge clk);
    if (reset) model_step(fs, wd, cd);
    else       model_reset();
    #1;
    bus_if.frame_start = 0;
    bus_if.wr_row_done = 0;
    bus_if.conv_done   = 0;
  endtask

  task automatic step(input bit fs, input bit wd, input bit cd);
    step_core(fs, wd, cd, 1'b0, dummy_v, 0);
  endtask

  initial begin
    logic [18:0] rst_out;
    dummy_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Frame 1 (ROWS=5): back-to-back loader, spurious conv_done, frame_start while busy.
    tbl.push_back(mk(1,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1, 1,0,0,0,0,1,0));
    tbl.push_back(mk(1,1,0, 1,1,0,0,0,1,0));
    tbl.push_back(mk(0,1,0, 1,2,0,0,0,1,0));
    tbl.push_back(mk(0,1,0, 1,3,0,0,0,1,0));
    tbl.push_back(mk(0,1,0, 0,0,1,0,0,1,0));
    tbl.push_back(mk(0,0,1, 0,0,0,0,0,1,0));
    tbl.push_back(mk(0,0,0, 0,0,0,0,0,1,0));
    tbl.push_back(mk(0,1,0, 1,0,0,1,1,1,0));
    tbl.push_back(mk(0,0,0, 0,1,1,1,1,1,0));
    tbl.push_back(mk(0,0,1, 0,1,0,1,1,1,0));
    tbl.push_back(mk(0,0,0, 0,1,0,1,1,1,0));
    tbl.push_back(mk(0,0,1, 0,1,0,2,2,1,0));
    tbl.push_back(mk(0,0,0, 0,1,1,2,2,1,0));
    tbl.push_back(mk(0,0,1, 0,1,0,2,2,1,0));
    tbl.push_back(mk(0,0,0, 0,1,0,2,2,1,0));
    tbl.push_back(mk(0,0,0, 0,1,0,3,2,1,1));
    // Frame 2: write coinciding with the retire cycle.
    tbl.push_back(mk(1,0,0, 0,1,0,1,2,0,0));
    tbl.push_back(mk(0,1,0, 1,1,0,1,0,1,0));
    tbl.push_back(mk(0,1,0, 1,2,0,1,0,1,0));
    tbl.push_back(mk(0,1,0, 1,3,0,1,0,1,0));
    tbl.push_back(mk(0,0,0, 1,0,0,1,0,1,0));
    tbl.push_back(mk(0,0,0, 1,0,1,1,0,1,0));
    tbl.push_back(mk(0,0,1, 1,0,0,1,0,1,0));
    tbl.push_back(mk(0,1,0, 1,0,0,1,0,1,0));
    tbl.push_back(mk(0,0,0, 1,1,0,2,1,1,0));
    tbl.push_back(mk(0,0,0, 1,1,1,2,1,1,0));
    tbl.push_back(mk(0,0,0, 1,1,0,2,1,1,0));

    reset = 1'b0;
    bus_if.frame_start = 0; bus_if.wr_row_done = 0; bus_if.conv_done = 0;
    model_reset();
    repeat (2) step(0, 0, 0);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      step_core(tbl[i].fs, tbl[i].wd, tbl[i].cd, 1'b1, tbl[i], i);

    // Now in CONV: reset must clear the outputs without waiting for a clock edge.
    #2 reset = 1'b0;
    #1;
    rst_out = pack_out(bus_if.wr_allow, bus_if.wr_bank, bus_if.conv_start, bus_if.rd_base,
                       bus_if.out_row, bus_if.busy, bus_if.frame_done);
    n_chk++;
    if (rst_out !== 19'd0) begin
      n_fail++;
      $display("FAIL async_rst outputs act=%h exp=0", rst_out);
    end
    model_reset();
    repeat (2) step(0, 0, 0);
    reset = 1'b1;

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);

`ifdef CONV_LINE_SCHED_STALL_EN
    reset = 1'b0;
    step(0, 0, 0);
    reset = 1'b1;
    step(1, 0, 0);
    repeat (3) step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    repeat (21) step(0, 0, 0);
    step(0, 1, 0);
    n_chk++;
    if (bus_if.stall_cnt < 16'd20) begin
      n_fail++;
      $display("FAIL stall_delay act=%0d exp>=20", bus_if.stall_cnt);
    end
    for (int i = 0; i < 100 && m_busy; i++) step(0, 1, 1);
    n_chk++;
    if (bus_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_end_timeout busy act=%b exp=0", bus_if.busy);
    end
    step(1, 0, 0);
    n_chk++;
    if (bus_if.stall_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL stall_clear act=%0d exp=0", bus_if.stall_cnt);
    end
`endif

    n_chk++;
    if (occ_viol != 0) begin
      n_fail++;
      $display("FAIL occ_range violations act=%0d exp=0", occ_viol);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_line_sched.md
# conv_line_sched

Line-buffer scheduler for the 3x3 convolution stage. Tracks a ring of four row BRAMs shared by the upstream pixel loader (writer) and the convolution layer (reader), grants the loader a free bank, and pulses the convolution layer's start input whenever three consecutive rows are resident. It also supplies the rotating base-bank index and retires the oldest row on each convolution row-done, sequencing one full frame per `frame_start`.

## Interface
- `ROWS`, 1080: input rows per frame; output rows = ROWS-2.
- `NBANK`, 4: row BRAMs in the ring; fixed at 4, 2-bit indices.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low; asserting clears all state immediately.
- `frame_start` input 1: one-cycle pulse; begins a frame when in IDLE, ignored otherwise.
- `wr_row_done` input 1: one-cycle pulse; loader finished writing a row into `wr_bank`.
- `conv_done` input 1: one-cycle pulse from the conv layer's row-complete (`calend`) output.
- `wr_allow` output 1: loader may write a row into `wr_bank`.
- `wr_bank` output 2: bank the next input row is written to.
- `conv_start` output 1: one-cycle pulse to the conv layer's `ready_in`.
- `rd_base` output 2: bank holding the top row of the current 3-row window.
- `out_row` output 11: index of the output row currently being or last computed.
- `busy` output 1: high outside IDLE.
- `frame_done` output 1: one-cycle pulse at frame completion.
- `stall_cnt` output 16: present only with the configuration macro.

## Operation
- States: IDLE, FILL, START, CONV, RETIRE, DONE.
- Counters: `occ` (0..4, resident rows), `in_row` (0..ROWS, rows accepted this frame), `out_row`.
- IDLE: `frame_start` -> clear `in_row`, `out_row`, `occ`; keep `wr_bank`/`rd_base`, forcing `rd_base`=`wr_bank`; go to FILL.
- `wr_allow` = (state != IDLE && state != DONE) && `occ` < 4 && `in_row` < ROWS.
- `wr_row_done` with `wr_allow` high: `wr_bank`++ mod 4, `in_row`++, `occ`++. If `wr_allow` is low, the pulse is ignored (protocol error; no counter change).
- FILL: `occ` >= 3 -> START.
- START: `conv_start`=1 for exactly this cycle -> CONV.
- CONV: wait for `conv_done` -> RETIRE.
- RETIRE (one cycle): `rd_base`++ mod 4, `occ`--.
  - If `out_row` == ROWS-3 -> DONE.
  - Else `out_row`++ -> FILL.
- DONE: drop the 2 remaining rows (`occ`<=0, `rd_base`<=`wr_bank`), pulse `frame_done` -> IDLE.
- Simultaneous `wr_row_done` and the RETIRE decrement in the same cycle: `occ` is unchanged, and both `wr_bank` and `rd_base` advance.
- `conv_done` outside CONV is ignored.
- Bank wrap: 3 -> 0 on both pointers.
- `occ` can never exceed 4 or go below 0. The bench asserts this.

## Timing
- Reset values: `wr_allow`=0, `wr_bank`=0, `conv_start`=0, `rd_base`=0, `out_row`=0, `busy`=0, `frame_done`=0, `stall_cnt`=0; state IDLE.
- `frame_start` at cycle t -> `busy`=1 and `wr_allow`=1 at t+1.
- Third accepted `wr_row_done` at t -> FILL sees `occ`=3 at t+1 -> `conv_start` high during t+2.
- `conv_done` at t -> RETIRE at t+1. With `occ` still >= 3, the next `conv_start` is at t+3. Minimum 3 cycles between `conv_done` and the following `conv_start`.
- The conv layer edge-detects `ready_in`, so `conv_start` is always a single-cycle pulse, with at least 2 low cycles between pulses.
- Reset mid-frame: all outputs return to their reset values asynchronously. The first edge after release is IDLE behaviour.

## Configuration
- `CONV_LINE_SCHED_STALL_EN` defined:
  - `stall_cnt` port and counter are present.
  - It increments, saturating at 16'hFFFF, every cycle in FILL with `occ` < 3 after the first output row of the frame.
  - It clears on `frame_start`.
- Undefined: no port and no counter logic; behaviour is otherwise identical.

## Test plan
- Reset then `frame_start`, ROWS=5: 3 `wr_row_done` pulses -> single `conv_start` 2 cycles after the third; `rd_base`=0.
- Loader writes back-to-back, ROWS=5 -> `wr_allow` drops after `occ`=4, with `wr_bank`=0 after the 4th write. The 5th write is accepted only after the first `conv_done` retires a row.
- Full frame ROWS=5 -> exactly 3 `conv_start` pulses with `rd_base` 0,1,2, then `frame_done` once. Afterwards `rd_base`=`wr_bank`=1 and `busy`=0.
- `wr_row_done` in the same cycle as RETIRE -> `occ` unchanged and both pointers advance by 1.
- Spurious `conv_done` in FILL and `frame_start` while busy -> no state change. Reset asserted during CONV -> all outputs are at reset values before the next clock edge.
- With the macro defined, delay the 4th row by 20 cycles after the first `conv_done` -> `stall_cnt` reads 20 or more, and 0 after the next `frame_start`.
